// File: rtl/status_blink_coder.sv
// Status blink coder: shows a status number on one LED as N pulses then a gap, one heartbeat edge per slot.
// Optional macro STATUS_BLINK_STICKY_EN: pending only accepts a higher code or an explicit clear.
module status_blink_coder #(
    parameter int CODE_W    = 4,
    parameter int GAP_BEATS = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enable,
    input  logic              i_beat_in,
    input  logic [CODE_W-1:0] i_code_in,
    input  logic              i_code_valid,
    output logic              o_led_out,
    output logic              o_code_busy,
    output logic [CODE_W-1:0] o_cur_code
);

    localparam int GW = (GAP_BEATS > 1) ? $clog2(GAP_BEATS) : 1;
    localparam logic [GW-1:0]     GAP_LAST = GW'(GAP_BEATS - 1);
    localparam logic [GW-1:0]     GAP_ONE  = GW'(1);
    localparam logic [CODE_W-1:0] CODE_ONE = CODE_W'(1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ON   = 2'd1;
    localparam logic [1:0] S_OFF  = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [1:0]        r_state;
    logic [CODE_W-1:0] r_pending;
    logic [CODE_W-1:0] r_cur_code;
    logic [CODE_W-1:0] r_pulse_cnt;
    logic [GW-1:0]     r_gap_cnt;
    logic              r_led;
    logic              r_beat_d;
    logic              w_tick;
    logic              w_accept;

    assign w_tick = i_beat_in ^ r_beat_d;

`ifdef STATUS_BLINK_STICKY_EN
    assign w_accept = i_code_valid && ((i_code_in > r_pending) || (i_code_in == '0));
`else
    assign w_accept = i_code_valid;
`endif

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_pending <= '0;
            r_beat_d  <= 1'b0;
        end else begin
            r_beat_d <= i_beat_in;
            if (w_accept) r_pending <= i_code_in;
        end
    end

    // The FSM reads r_pending before this clock's write lands, so a
    // simultaneous write is only seen at the next load point.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= S_IDLE;
            r_cur_code  <= '0;
            r_pulse_cnt <= '0;
            r_gap_cnt   <= '0;
            r_led       <= 1'b0;
        end else if (!i_enable) begin
            r_state     <= S_IDLE;
            r_cur_code  <= '0;
            r_pulse_cnt <= '0;
            r_gap_cnt   <= '0;
            r_led       <= 1'b0;
        end else if (w_tick) begin
            case (r_state)
                S_IDLE: begin
                    r_led <= i_beat_in;
                    if (r_pending != '0) begin
                        r_cur_code  <= r_pending;
                        r_pulse_cnt <= '0;
                        r_led       <= 1'b1;
                        r_state     <= S_ON;
                    end
                end
                S_ON: begin
                    r_led   <= 1'b0;
                    r_state <= S_OFF;
                end
                S_OFF: begin
                    if (r_pulse_cnt == r_cur_code - CODE_ONE) begin
                        r_gap_cnt <= '0;
                        r_state   <= S_GAP;
                    end else begin
                        r_pulse_cnt <= r_pulse_cnt + CODE_ONE;
                        r_led       <= 1'b1;
                        r_state     <= S_ON;
                    end
                end
                S_GAP: begin
                    r_led <= 1'b0;
                    if (r_gap_cnt == GAP_LAST) begin
                        if (r_pending == '0) begin
                            r_cur_code <= '0;
                            r_state    <= S_IDLE;
                        end else begin
                            r_cur_code  <= r_pending;
                            r_pulse_cnt <= '0;
                            r_led       <= 1'b1;
                            r_state     <= S_ON;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GAP_ONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_led_out   = r_led;
    assign o_code_busy = (r_state != S_IDLE);
    assign o_cur_code  = r_cur_code;

endmodule

// File: tb/tb_status_blink_coder.sv
// Scoreboard bench for status_blink_coder: beat_in toggles every 10 clk, a cycle model predicts outputs.
module tb_status_blink_coder;
    localparam int CODE_W    = 4;
    localparam int GAP_BEATS = 4;

    logic              clk = 1'b0;
    logic              rst, en, beat, cv;
    logic [CODE_W-1:0] ci;
    logic              led, busy;
    logic [CODE_W-1:0] cur;

    always #5 clk = ~clk;

    status_blink_coder #(.CODE_W(CODE_W), .GAP_BEATS(GAP_BEATS)) dut (
        .i_clk(clk), .i_rst(rst), .i_enable(en), .i_beat_in(beat),
        .i_code_in(ci), .i_code_valid(cv),
        .o_led_out(led), .o_code_busy(busy), .o_cur_code(cur)
    );

    int n_chk = 0, n_pass = 0;
    int m_st, m_pend, m_cur, m_pc, m_gc, m_led, m_bd;
    int exp_q[$];
    int beat_cnt = 0, rise_cnt = 0;
    logic led_prev = 1'b0;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d at %0t", tag, act, exp, $time);
    endtask

    task automatic model_reset();
        m_st = 0; m_pend = 0; m_cur = 0; m_pc = 0; m_gc = 0; m_led = 0; m_bd = 0;
    endtask

    // Slot-level reference: 0=IDLE 1=ON 2=OFF 3=GAP
    task automatic model_step();
        bit tick;
        tick = (int'(beat) != m_bd);
        if (!en) begin
            m_st = 0; m_led = 0; m_pc = 0; m_gc = 0; m_cur = 0;
        end else if (tick) begin
            case (m_st)
                0: if (m_pend != 0) begin m_cur = m_pend; m_pc = 0; m_led = 1; m_st = 1; end
                   else m_led = int'(beat);
                1: begin m_led = 0; m_st = 2; end
                2: if (m_pc + 1 == m_cur) begin m_gc = 0; m_st = 3; end
                   else begin m_pc++; m_led = 1; m_st = 1; end
                default: begin
                    m_led = 0;
                    if (m_gc + 1 == GAP_BEATS) begin
                        if (m_pend == 0) begin m_cur = 0; m_st = 0; end
                        else begin m_cur = m_pend; m_pc = 0; m_led = 1; m_st = 1; end
                    end else m_gc++;
                end
            endcase
        end
`ifdef STATUS_BLINK_STICKY_EN
        if (cv && (int'(ci) > m_pend || ci == 0)) m_pend = int'(ci);
`else
        if (cv) m_pend = int'(ci);
`endif
        m_bd = int'(beat);
    endtask

    task automatic cyc(input logic v, input logic [CODE_W-1:0] c);
        int e;
        beat_cnt++;
        if (beat_cnt == 10) begin beat_cnt = 0; beat = ~beat; end
        cv = v; ci = c;
        model_step();
        exp_q.push_back((m_led << 5) | ((m_st != 0) << 4) | m_cur);
        @(posedge clk); #1;
        e = exp_q.pop_front();
        chk("led", led, (e >> 5) & 1);
        chk("busy", busy, (e >> 4) & 1);
        chk("cur", cur, e & 15);
        if (led && !led_prev) rise_cnt++;
        led_prev = led;
        cv = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0);
    endtask

    // Advance until the model reaches state st (and pulse count pc if pc>=0), bounded.
    task automatic wait_model(input int st, input int pc, input int maxc, input string tag);
        int k;
        k = 0;
        while (!(m_st == st && (pc < 0 || m_pc == pc)) && k < maxc) begin
            cyc(1'b0, '0);
            k++;
        end
        if (k >= maxc) chk(tag, 0, 1);
    endtask

    initial begin
        int want6;
        rst = 1'b0; en = 1'b0; beat = 1'b0; cv = 1'b0; ci = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_led", led, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cur", cur, 0);
        rst = 1'b1; en = 1'b1;

        // heartbeat passthrough with no code
        run(60);

        // code 3: three pulses per 100-clk period
        cyc(1'b1, 4'd3);
        wait_model(1, 0, 30, "t2_start");
        run(200);
        rise_cnt = 0;
        run(100);
        chk("pulses3", rise_cnt, 3);

        // write 5 during pulse 2 of code 3; 3 finishes first
        wait_model(1, 1, 200, "t3_pulse2");
        cyc(1'b1, 4'd5);
        chk("t3_keep3", cur, 3);
        wait_model(3, -1, 100, "t3_gap");
        chk("t3_gap_cur", cur, 3);
        wait_model(1, 0, 100, "t3_load5");
        chk("t3_cur5", cur, 5);
        rise_cnt = 0;
        run(140);
        chk("pulses5", rise_cnt, 5);

        // clear, then write 2 on the very tick that would leave IDLE
        cyc(1'b1, 4'd0);
        wait_model(0, -1, 300, "t4_idle");
        while (beat_cnt != 9) cyc(1'b0, '0);
        cyc(1'b1, 4'd2);
        chk("t4_still_idle", busy, 0);
        run(10);
        chk("t4_busy", busy, 1);
        chk("t4_cur2", cur, 2);

        // enable drop mid-ON, then resume with the same pending code
        wait_model(1, -1, 100, "t5_on");
        en = 1'b0;
        cyc(1'b0, '0);
        chk("t5_led_off", led, 0);
        chk("t5_idle", busy, 0);
        run(25);
        en = 1'b1;
        wait_model(1, 0, 40, "t5_restart");
        chk("t5_cur2", cur, 2);

        // 6 then 2: sticky keeps 6, plain build takes 2
        cyc(1'b1, 4'd6);
        run(5);
        cyc(1'b1, 4'd2);
`ifdef STATUS_BLINK_STICKY_EN
        want6 = 6;
`else
        want6 = 2;
`endif
        wait_model(3, -1, 200, "t6_gap");
        wait_model(1, 0, 100, "t6_load");
        chk("t6_code", cur, want6);
        cyc(1'b1, 4'd0);
        wait_model(0, -1, 400, "t6_clear");
        chk("t6_idle", busy, 0);

        // full-range code 15, then async reset mid-sequence clears pending too
        cyc(1'b1, 4'd15);
        wait_model(1, 14, 400, "t7_pulse15");
        chk("t7_cur15", cur, 15);
        #2 rst = 1'b0;
        #1;
        chk("t7_rst_led", led, 0);
        chk("t7_rst_busy", busy, 0);
        chk("t7_rst_cur", cur, 0);
        model_reset();
        rst = 1'b1;
        run(50);
        chk("t7_no_pending", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
